mac_vlg_rx: RTL
===============

MAC_VLG_RX -- requirements
Module: mac_vlg_rx

Interface
REQ-001 The block SHALL have parameter VERIFY_FCS, default 1, meaning: 1 = check CRC-32 and flag failures, 0 = strip FCS without checking.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous active-low reset.
- mac_addr  in  mac_addr_t  local station address.
- phy_dat  in  8  received byte, first byte of preamble first.
- phy_val  in  1  byte valid; deasserted at least one cycle between frames.
- phy_err  in  1  PHY symbol error, sampled with phy_val.
- rx_dat  out  8  payload byte.
- rx_val  out  1  payload byte valid.
- rx_sof  out  1  first payload byte.
- rx_eof  out  1  last payload byte.
- rx_err  out  1  frame bad; valid with rx_eof.
- rx_meta  out  mac_meta_t  header and length of the current frame.

Function
REQ-003 The block SHALL implement an FSM with states IDLE, PRE, HDR, PLD and DROP.
REQ-004 IDLE SHALL go to PRE on the first phy_val byte equal to 8'h55.
REQ-005 PRE SHALL require exactly 6 more 8'h55 bytes followed by 8'hd5 (the PREAMBLE constant), then go to HDR; any other byte SHALL go to DROP.
REQ-006 HDR SHALL capture 14 bytes MSB-first into mac_hdr_t (dst_mac, src_mac, ethertype), then go to PLD.
REQ-007 After the last header byte, the frame SHALL be accepted only if dst_mac equals mac_addr or MAC_BROADCAST; otherwise the FSM SHALL go to DROP.
REQ-008 PLD SHALL shift each byte into a 5-byte delay line.
REQ-009 Payload byte j SHALL appear on rx_dat one cycle after byte j+5 is sampled.
REQ-010 On the first cycle of PLD with phy_val low, the oldest delay-line byte SHALL be emitted with rx_eof=1; the 4 newer bytes are the FCS and SHALL never be output.
REQ-011 rx_sof SHALL be asserted with the first emitted byte only; a single-byte payload SHALL assert rx_sof and rx_eof together.
REQ-012 rx_meta.val and rx_meta.hdr SHALL be valid from rx_sof through rx_eof and held stable until the next rx_sof.
REQ-013 rx_meta.length SHALL equal the payload byte count (FCS excluded) and SHALL be valid in the rx_eof cycle.
REQ-014 The CRC-32 (reflected, poly 0x04C11DB7, init 32'hFFFFFFFF) SHALL run over header, payload and FCS; the frame is good iff the final register equals 32'hDEBB20E3.
REQ-015 rx_err SHALL be set with rx_eof if the CRC is bad (when VERIFY_FCS=1) or if phy_err was seen in any HDR/PLD byte.
REQ-016 If phy_val falls during PRE or HDR, the FSM SHALL return to IDLE with no output.
REQ-017 If phy_val falls in PLD with fewer than 5 post-header bytes (no payload), the FSM SHALL return to IDLE with no output.
REQ-018 DROP SHALL discard bytes until phy_val is low, then go to IDLE.
REQ-019 rx_val SHALL never be asserted for a dropped frame.
REQ-020 The block SHALL have no backpressure; rx_* are registered outputs.
REQ-021 The length counter SHALL be length_t wide and saturate at all-ones.

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, empty the delay line, CRC to all ones, length to 0, and all rx_* outputs and rx_meta to 0.
REQ-023 Assertion of rst_n mid-frame SHALL abort the frame with no rx_eof.
REQ-024 After rst_n rises, a frame whose preamble started before release SHALL be ignored until phy_val is low.

Structure
REQ-025 PREAMBLE, MAC_BROADCAST, fcs_t, mac_hdr_t and mac_meta_t SHALL be taken from mac_vlg_pkg.
REQ-026 The CRC residue constant 32'hDEBB20E3 and the FSM state enum SHALL be added to mac_vlg_pkg.
REQ-027 The byte-wide CRC-32 SHALL be a sub-module, crc32_byte (inputs clk, rst_n, init, dat, val; output crc), reusable by the TX path.

Verification
REQ-028 Unicast frame to mac_addr 02:00:00:00:00:01, ethertype 16'h0800, 46-byte incrementing payload, correct FCS -> 46 rx_val bytes 00..2D, sof on byte 00, eof on byte 2D, rx_err=0, length=46.
REQ-029 Same frame with one payload bit flipped -> identical data output, rx_err=1 at eof; with VERIFY_FCS=0 -> rx_err=0.
REQ-030 dst ff:ff:ff:ff:ff:ff -> accepted; dst 02:00:00:00:00:02 -> no rx_val at all.
REQ-031 Preamble with 6th byte 8'h54 -> DROP, no output; a good frame 1 cycle after phy_val low -> received normally.
REQ-032 Frame with 1-byte payload 8'hA5 -> single cycle with rx_sof=rx_eof=1, rx_dat=A5, length=1.
REQ-033 rst_n pulsed low at payload byte 20 -> all outputs 0 immediately, no eof; the following frame is received correctly.

Source files
------------

// File: rtl/mac_vlg_pkg.sv
// Shared Ethernet RX/TX types, constants and the byte-wise reflected CRC-32 step.
package mac_vlg_pkg;

    typedef logic [47:0] mac_addr_t;
    typedef logic [31:0] fcs_t;
    typedef logic [15:0] length_t;

    typedef struct packed {
        mac_addr_t   dst_mac;
        mac_addr_t   src_mac;
        logic [15:0] ethertype;
    } mac_hdr_t;

    typedef struct packed {
        logic     val;
        mac_hdr_t hdr;
        length_t  length;
    } mac_meta_t;

    localparam logic [63:0] PREAMBLE      = 64'h5555_5555_5555_55d5;
    localparam mac_addr_t   MAC_BROADCAST = 48'hffff_ffff_ffff;
    localparam fcs_t        CRC_RESIDUE   = 32'hDEBB20E3;
    localparam fcs_t        CRC_POLY_REFL = 32'hEDB88320;
    localparam int          HDR_BYTES     = 14;
    localparam int          DLY_BYTES     = 5;

    typedef enum logic [2:0] {IDLE, PRE, HDR, PLD, DROP} rx_state_t;

    // LSB-first CRC-32 update by one byte (0x04C11DB7 bit-reversed)
    function automatic fcs_t crc32_next(input fcs_t crc, input logic [7:0] dat);
        fcs_t c;
        c = crc ^ {24'h0, dat};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Byte-serial CRC-32 register; init reloads all ones, val folds in one byte.
module crc32_byte
    import mac_vlg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic [7:0] dat,
    input  logic       val,
    output fcs_t       crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '1;
        end else if (init) begin
            crc <= '1;
        end else if (val) begin
            crc <= crc32_next(crc, dat);
        end
    end

endmodule

// File: rtl/mac_vlg_rx.sv
// Ethernet receive framer: preamble/SFD sync, header capture and address filter,
// FCS stripping through a 5-byte delay line, CRC and symbol-error reporting.
module mac_vlg_rx
    import mac_vlg_pkg::*;
#(
    parameter bit VERIFY_FCS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  mac_addr_t  mac_addr,
    input  logic [7:0] phy_dat,
    input  logic       phy_val,
    input  logic       phy_err,
    output logic [7:0] rx_dat,
    output logic       rx_val,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_err,
    output mac_meta_t  rx_meta
);

    rx_state_t   state;
    logic [3:0]  cnt;
    logic [2:0]  dly_cnt;
    logic [39:0] dly;
    mac_hdr_t    hdr_sr;
    mac_hdr_t    hdr_next;
    logic        armed;
    logic        bad_sym;
    logic        first;
    fcs_t        crc;
    logic        emit;
    logic        frame_bad;
    logic [7:0]  pre_bytes [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_pre
        assign pre_bytes[gi] = PREAMBLE[63-8*gi -: 8];
    end

    crc32_byte u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (state == PRE),
        .dat   (phy_dat),
        .val   (phy_val && (state == HDR || state == PLD)),
        .crc   (crc)
    );

    assign hdr_next  = {hdr_sr[HDR_BYTES*8-9:0], phy_dat};
    // The oldest byte leaves the line only once the 4 FCS bytes are behind it
    assign emit      = (state == PLD) && (dly_cnt == 3'(DLY_BYTES));
    assign frame_bad = bad_sym || (VERIFY_FCS && (crc != CRC_RESIDUE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dly_cnt <= '0;
            dly     <= '0;
            hdr_sr  <= '0;
            armed   <= 1'b0;
            bad_sym <= 1'b0;
            first   <= 1'b0;
            rx_dat  <= '0;
            rx_val  <= 1'b0;
            rx_sof  <= 1'b0;
            rx_eof  <= 1'b0;
            rx_err  <= 1'b0;
            rx_meta <= '0;
        end else begin
            rx_val <= 1'b0;
            rx_sof <= 1'b0;
            rx_eof <= 1'b0;
            rx_err <= 1'b0;
            // A frame already in flight at reset release is skipped until the gap
            if (!phy_val) armed <= 1'b1;

            case (state)
                IDLE: if (phy_val && armed) begin
                    if (phy_dat == pre_bytes[0]) begin
                        state <= PRE;
                        cnt   <= 4'd1;
                    end else begin
                        state <= DROP;
                    end
                end
                PRE: if (!phy_val) begin
                    state <= IDLE;
                end else if (phy_dat != pre_bytes[cnt[2:0]]) begin
                    state <= DROP;
                end else if (cnt == 4'd7) begin
                    state   <= HDR;
                    cnt     <= '0;
                    bad_sym <= 1'b0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                HDR: if (!phy_val) begin
                    state <= IDLE;
                end else begin
                    hdr_sr  <= hdr_next;
                    bad_sym <= bad_sym | phy_err;
                    if (cnt == 4'(HDR_BYTES - 1)) begin
                        if (hdr_next.dst_mac == mac_addr || hdr_next.dst_mac == MAC_BROADCAST) begin
                            state   <= PLD;
                            dly_cnt <= '0;
                            first   <= 1'b1;
                        end else begin
                            state <= DROP;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                PLD: if (phy_val) begin
                    dly     <= {dly[31:0], phy_dat};
                    bad_sym <= bad_sym | phy_err;
                    if (!emit) dly_cnt <= dly_cnt + 3'd1;
                end else begin
                    state   <= IDLE;
                    dly_cnt <= '0;
                end
                DROP: if (!phy_val) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (emit) begin
                rx_val <= 1'b1;
                rx_dat <= dly[39:32];
                rx_sof <= first;
                rx_eof <= !phy_val;
                rx_err <= !phy_val && frame_bad;
                first  <= 1'b0;
                if (first) begin
                    rx_meta <= '{val: 1'b1, hdr: hdr_sr, length: length_t'(1)};
                end else if (rx_meta.length != '1) begin
                    rx_meta.length <= rx_meta.length + length_t'(1);
                end
            end
        end
    end

endmodule
